// File: rtl/baud_tick_gen_if.sv
// Port bundle for baud_tick_gen: timing controls from the RX start detector
// and tick/index/busy results for the RX shift FSM.
interface baud_tick_gen_if #(
    parameter int Width     = 16,
    parameter int FracWidth = 4,
    parameter int CntWidth  = 4
);
    logic                 start_i;
    logic                 stop_i;
    logic                 en_i;
    logic [Width-1:0]     baud_i;
    logic [FracWidth-1:0] frac_i;
    logic                 tick_o;
    logic [CntWidth-1:0]  idx_o;
    logic                 busy_o;

    modport master (
        output start_i, stop_i, en_i, baud_i, frac_i,
        input  tick_o, idx_o, busy_o
    );

    modport slave (
        input  start_i, stop_i, en_i, baud_i, frac_i,
        output tick_o, idx_o, busy_o
    );
endinterface

// File: rtl/baud_tick_gen.sv
// UART RX baud tick generator: half-period first tick, then one tick per bit period.
// Define BAUD_FRAC_EN to add the fractional divisor (accumulator + stretch cycle).
module baud_tick_gen #(
    parameter int Width     = 16,
    parameter int FracWidth = 4,
    parameter int CntWidth  = 4
) (
    input logic            clk_i,
    input logic            rst_i,
    baud_tick_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HALF, RUN} state_t;

    state_t              r_state, w_stateNext;
    logic [Width-1:0]    r_cnt, w_cntNext;
    logic [CntWidth-1:0] r_idx, w_idxNext;
    logic                r_tick, w_tickNext;
    logic                w_stretch;

`ifdef BAUD_FRAC_EN
    logic [FracWidth-1:0] r_acc, w_accNext;
    logic                 r_stretch, w_stretchNext;
    logic [FracWidth:0]   w_accSum;

    assign w_accSum  = {1'b0, r_acc} + {1'b0, bus.frac_i};
    assign w_stretch = r_stretch;
`else
    logic w_unusedFrac;

    assign w_unusedFrac = ^bus.frac_i;
    assign w_stretch    = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_tick    <= 1'b0;
`ifdef BAUD_FRAC_EN
            r_acc     <= '0;
            r_stretch <= 1'b0;
`endif
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_idx     <= w_idxNext;
            r_tick    <= w_tickNext;
`ifdef BAUD_FRAC_EN
            r_acc     <= w_accNext;
            r_stretch <= w_stretchNext;
`endif
        end
    end

    // Priority: start (restart from any state) > stop > enabled counting.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_idxNext     = r_idx;
        w_tickNext    = 1'b0;
`ifdef BAUD_FRAC_EN
        w_accNext     = r_acc;
        w_stretchNext = r_stretch;
`endif
        if (bus.start_i) begin
            w_stateNext   = HALF;
            w_cntNext     = bus.baud_i >> 1;
            w_idxNext     = '0;
`ifdef BAUD_FRAC_EN
            w_accNext     = '0;
            w_stretchNext = 1'b0;
`endif
        end else if (r_state != IDLE) begin
            if (bus.stop_i) begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end else if (bus.en_i) begin
                if (r_cnt != '0) begin
                    w_cntNext = r_cnt - Width'(1);
                end else if (!w_stretch) begin
                    w_tickNext  = 1'b1;
                    w_idxNext   = r_idx + CntWidth'(1);
                    w_cntNext   = bus.baud_i;
                    w_stateNext = RUN;
`ifdef BAUD_FRAC_EN
                    // The half-period reload does not accumulate fraction.
                    if (r_state == RUN) begin
                        w_accNext     = w_accSum[FracWidth-1:0];
                        w_stretchNext = w_accSum[FracWidth];
                    end
`endif
                end
`ifdef BAUD_FRAC_EN
                else begin
                    w_stretchNext = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.tick_o = r_tick;
    assign bus.idx_o  = r_idx;
    assign bus.busy_o = (r_state != IDLE);
endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed timing scenarios plus randomized traffic,
// with a cycle-countdown reference model compared on every falling edge.
module tb_baud_tick_gen;
   localparam int Width     = 16;
   localparam int FracWidth = 4;
   localparam int CntWidth  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   baud_tick_gen_if #(.Width(Width), .FracWidth(FracWidth), .CntWidth(CntWidth)) bus ();

   baud_tick_gen #(.Width(Width), .FracWidth(FracWidth), .CntWidth(CntWidth)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: counts enabled cycles remaining until the next tick.
   // A fractional carry simply makes the following period one cycle longer.
   bit mActive;
   bit mRun;
   bit mTick;
   int mLeft;
   int mIdx;
   int mAcc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mActive = 1'b0;
         mRun    = 1'b0;
         mTick   = 1'b0;
         mLeft   = 0;
         mIdx    = 0;
         mAcc    = 0;
      end else begin
         mTick = 1'b0;
         if (bus.start_i) begin
            mActive = 1'b1;
            mRun    = 1'b0;
            mIdx    = 0;
            mAcc    = 0;
            mLeft   = int'(bus.baud_i >> 1) + 1;
         end else if (mActive && bus.stop_i) begin
            mActive = 1'b0;
         end else if (mActive && bus.en_i) begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
               int extra;
               extra = 0;
               mTick = 1'b1;
               mIdx  = (mIdx + 1) % (1 << CntWidth);
`ifdef BAUD_FRAC_EN
               if (mRun) begin
                  mAcc = mAcc + int'(bus.frac_i);
                  if (mAcc >= (1 << FracWidth)) begin
                     extra = 1;
                     mAcc  = mAcc - (1 << FracWidth);
                  end
               end
`endif
               mLeft = int'(bus.baud_i) + 1 + extra;
               mRun  = 1'b1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every falling edge the DUT outputs must match the model.
   always @(negedge clk) begin
      checkOutput("model_tick", int'(bus.tick_o), int'(mTick));
      checkOutput("model_idx", int'(bus.idx_o), mIdx);
      checkOutput("model_busy", int'(bus.busy_o), int'(mActive));
   end

   task automatic pulseStart(input int baud, input bit withStop);
      bus.baud_i  = Width'(baud);
      bus.start_i = 1'b1;
      bus.stop_i  = withStop;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.stop_i  = 1'b0;
   endtask

   task automatic pulseStop();
      bus.stop_i = 1'b1;
      @(negedge clk);
      bus.stop_i = 1'b0;
   endtask

   // Counts falling edges until tick_o is seen; -1 when the budget runs out.
   task automatic waitTick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.tick_o && n < 300);
      if (!bus.tick_o) n = -1;
   endtask

   task automatic countTicks(input int cycles, output int ticks);
      ticks = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus.tick_o) ticks++;
      end
   endtask

   task automatic applyStimulus();
      bus.start_i = ($urandom_range(0, 29) == 0);
      bus.stop_i  = ($urandom_range(0, 39) == 0);
      bus.en_i    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) bus.baud_i = Width'($urandom_range(0, 14));
      bus.frac_i  = FracWidth'($urandom_range(0, 15));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int total;
      int longCnt;
      bus.start_i = 1'b0;
      bus.stop_i  = 1'b0;
      bus.en_i    = 1'b1;
      bus.baud_i  = Width'(9);
      bus.frac_i  = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_tick", int'(bus.tick_o), 0);
      checkOutput("reset_idx", int'(bus.idx_o), 0);
      checkOutput("reset_busy", int'(bus.busy_o), 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] baud 9 nominal timing");
      pulseStart(9, 1'b0);
      checkOutput("busy_after_start", int'(bus.busy_o), 1);
      waitTick(n);
      checkOutput("first_tick_delay", n, 5);
      checkOutput("first_tick_idx", int'(bus.idx_o), 1);
      for (int i = 2; i <= 4; i++) begin
         waitTick(n);
         checkOutput("period_9", n, 10);
         checkOutput("idx_run", int'(bus.idx_o), i);
      end

      $display("[TB] enable gap");
      repeat (3) @(negedge clk);
      bus.en_i = 1'b0;
      repeat (3) @(negedge clk);
      bus.en_i = 1'b1;
      waitTick(n);
      checkOutput("en_gap_period", (n < 0) ? n : n + 6, 13);
      waitTick(n);
      checkOutput("after_gap_period", n, 10);

      $display("[TB] restart in RUN");
      repeat (4) @(negedge clk);
      pulseStart(9, 1'b0);
      waitTick(n);
      checkOutput("restart_delay", n, 5);
      checkOutput("restart_idx", int'(bus.idx_o), 1);
      repeat (4) @(negedge clk);
      pulseStart(9, 1'b1);
      checkOutput("start_beats_stop", int'(bus.busy_o), 1);
      waitTick(n);
      checkOutput("start_stop_delay", n, 5);
      checkOutput("start_stop_idx", int'(bus.idx_o), 1);

      pulseStop();
      checkOutput("busy_after_stop", int'(bus.busy_o), 0);
      countTicks(30, n);
      checkOutput("idle_ticks", n, 0);

      $display("[TB] baud 0 continuous ticks");
      pulseStart(0, 1'b0);
      waitTick(n);
      checkOutput("b0_first_delay", n, 1);
      for (int i = 2; i <= 17; i++) begin
         @(negedge clk);
         checkOutput("b0_tick", int'(bus.tick_o), 1);
         checkOutput("b0_idx_wrap", int'(bus.idx_o), i % 16);
      end
      pulseStop();

      $display("[TB] fractional divisor");
      bus.frac_i = FracWidth'(4);
      pulseStart(9, 1'b0);
      waitTick(n);
      waitTick(n);
      total   = 0;
      longCnt = 0;
      repeat (16) begin
         waitTick(n);
         total += n;
         if (n == 11) longCnt++;
      end
`ifdef BAUD_FRAC_EN
      checkOutput("frac_total", total, 164);
      checkOutput("frac_long_periods", longCnt, 4);
`else
      checkOutput("frac_total", total, 160);
      checkOutput("frac_long_periods", longCnt, 0);
`endif
      bus.frac_i = '0;
      pulseStop();

      $display("[TB] asynchronous reset mid-RUN");
      pulseStart(9, 1'b0);
      repeat (3) waitTick(n);
      checkOutput("pre_reset_idx", int'(bus.idx_o), 3);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_tick", int'(bus.tick_o), 0);
      checkOutput("async_rst_idx", int'(bus.idx_o), 0);
      checkOutput("async_rst_busy", int'(bus.busy_o), 0);
      @(negedge clk);
      rst = 1'b0;
      countTicks(30, n);
      checkOutput("post_reset_ticks", n, 0);

      $display("[TB] randomized traffic");
      bus.baud_i = Width'(5);
      repeat (4000) begin
         applyStimulus();
         @(negedge clk);
      end
      bus.start_i = 1'b0;
      bus.stop_i  = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
